// File: rtl/par2ser_pkg.sv
// Shared constants for the parallel-to-serial / serial-to-parallel stream blocks.
package par2ser_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  localparam bit DIR_LSB = 1'b1;
  localparam bit DIR_MSB = 1'b0;

  function automatic int clog2(input int v);
    for (int r = 0; r < 32; r++)
      if ((1 << r) >= v) return r;
    return 32;
  endfunction

endpackage

// File: rtl/par2ser_bitcnt.sv
// Remaining-bit counter: loads WIDTH, counts down on dec, flags the final bit.
module par2ser_bitcnt
  import par2ser_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          is_last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (load)            cnt <= CW'(WIDTH);
    else if (dec && cnt != 0) cnt <= cnt - 1'b1;
  end

  assign is_last = (cnt == CW'(1));

endmodule

// File: rtl/par2ser_stream.sv
// Parallel-to-serial converter with a Mealy load handshake so words stream
// back-to-back; direction, fill bit and width are parameters.
module par2ser_stream
  import par2ser_pkg::*;
#(
  parameter  int   WIDTH     = 8,
  parameter  bit   LSB_FIRST = DIR_LSB,
  parameter  logic FILL      = 1'b0,
  localparam int   CW        = clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic [WIDTH-1:0] shreg,
  output logic [CW-1:0]    bit_cnt,
  output logic             busy
);

  if (WIDTH < 1) begin : g_bad_width
    $error("par2ser_stream: WIDTH must be >= 1");
  end

  logic             state, state_nxt;
  logic             is_last, step, accept;
  logic [WIDTH-1:0] shifted;

  assign step       = (state == ST_SHIFT) & shift_en;
  assign load_ready = (state == ST_IDLE) | (step & is_last);
  assign accept     = load_valid & load_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
      ST_SHIFT: if (step && is_last && !accept) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == ST_SHIFT);
    ser_valid = busy;
    ser_out   = busy & (LSB_FIRST ? shreg[0] : shreg[WIDTH-1]);
    ser_last  = busy & is_last;
  end

  // A single-bit register has no neighbour to shift in, only the fill bit.
  if (WIDTH == 1) begin : g_sh1
    assign shifted = FILL;
  end else if (LSB_FIRST) begin : g_shr
    assign shifted = {FILL, shreg[WIDTH-1:1]};
  end else begin : g_shl
    assign shifted = {shreg[WIDTH-2:0], FILL};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         shreg <= '0;
    else if (accept) shreg <= din;
    else if (step)   shreg <= shifted;
  end

  par2ser_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .dec     (step & ~accept),
    .cnt     (bit_cnt),
    .is_last (is_last)
  );

endmodule

// File: tb/tb_par2ser_stream.sv
// Drives three converter configurations against a word/bit-index reference model.
module tb_par2ser_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] din8;
  logic       lv8, se8;
  logic       din1, lv1, se1;

  logic [2:0] lr, so, sv, sl, by;
  logic [7:0] sh0, sh1;
  logic [0:0] sh2;
  logic [3:0] bc0, bc1;
  logic [0:0] bc2;

  par2ser_stream #(.WIDTH(8), .LSB_FIRST(1'b1), .FILL(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din8), .load_valid(lv8), .load_ready(lr[0]),
    .shift_en(se8), .ser_out(so[0]), .ser_valid(sv[0]), .ser_last(sl[0]),
    .shreg(sh0), .bit_cnt(bc0), .busy(by[0]));

  par2ser_stream #(.WIDTH(8), .LSB_FIRST(1'b0), .FILL(1'b0)) u_msb (
    .clk(clk), .rst(rst), .din(din8), .load_valid(lv8), .load_ready(lr[1]),
    .shift_en(se8), .ser_out(so[1]), .ser_valid(sv[1]), .ser_last(sl[1]),
    .shreg(sh1), .bit_cnt(bc1), .busy(by[1]));

  par2ser_stream #(.WIDTH(1), .LSB_FIRST(1'b1), .FILL(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .din(din1), .load_valid(lv1), .load_ready(lr[2]),
    .shift_en(se1), .ser_out(so[2]), .ser_valid(sv[2]), .ser_last(sl[2]),
    .shreg(sh2), .bit_cnt(bc2), .busy(by[2]));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: the loaded word plus how many of its bits have been consumed.
  int         mw[3]   = '{8, 8, 1};
  bit         mlsb[3] = '{1'b1, 1'b0, 1'b1};
  bit         mfill[3] = '{1'b0, 1'b0, 1'b1};
  bit         mact[3];
  int         mk[3];
  logic [7:0] mword[3];

  task automatic mreset();
    for (int i = 0; i < 3; i++) begin
      mact[i] = 1'b0; mk[i] = 0; mword[i] = '0;
    end
  endtask

  function automatic logic lv_of(int i);  return (i < 2) ? lv8 : lv1; endfunction
  function automatic logic se_of(int i);  return (i < 2) ? se8 : se1; endfunction
  function automatic logic [7:0] din_of(int i); return (i < 2) ? din8 : {7'b0, din1}; endfunction

  function automatic logic [7:0] e_sh(int i);
    int w = mw[i];
    int k = mk[i];
    logic [7:0] mask = 8'((1 << w) - 1);
    logic [7:0] v;
    if (mlsb[i]) begin
      v = mword[i] >> k;
      if (mfill[i]) v = v | (mask & ~8'((1 << (w - k)) - 1));
    end else begin
      v = (mword[i] << k) & mask;
      if (mfill[i]) v = v | 8'((1 << k) - 1);
    end
    return v & mask;
  endfunction

  function automatic logic e_bit(int i);
    logic [7:0] wd = mword[i];
    return mlsb[i] ? wd[mk[i]] : wd[mw[i] - 1 - mk[i]];
  endfunction

  function automatic logic e_ready(int i);
    return !mact[i] || (se_of(i) && (mw[i] - mk[i]) == 1);
  endfunction

  task automatic chk_dut(input int i);
    logic [7:0] a_sh;
    logic [3:0] a_bc;
    int rem;
    case (i)
      0:       begin a_sh = sh0;           a_bc = bc0;           end
      1:       begin a_sh = sh1;           a_bc = bc1;           end
      default: begin a_sh = {7'b0, sh2};   a_bc = {3'b0, bc2};   end
    endcase
    rem = mact[i] ? mw[i] - mk[i] : 0;
    chk($sformatf("d%0d_load_ready", i), lr[i], e_ready(i));
    chk($sformatf("d%0d_ser_valid", i),  sv[i], mact[i]);
    chk($sformatf("d%0d_busy", i),       by[i], mact[i]);
    chk($sformatf("d%0d_ser_last", i),   sl[i], mact[i] && rem == 1);
    chk($sformatf("d%0d_ser_out", i),    so[i], mact[i] ? e_bit(i) : 1'b0);
    chk($sformatf("d%0d_bit_cnt", i),    a_bc, rem);
    chk($sformatf("d%0d_shreg", i),      a_sh, e_sh(i));
  endtask

  task automatic upd(input int i);
    if (lv_of(i) && e_ready(i)) begin
      mword[i] = din_of(i); mk[i] = 0; mact[i] = 1'b1;
    end else if (mact[i] && se_of(i)) begin
      mk[i]++;
      if (mk[i] == mw[i]) mact[i] = 1'b0;
    end
  endtask

  // Called just after a falling edge with inputs already set.
  task automatic cyc();
    #1;
    if (rst) mreset();
    for (int i = 0; i < 3; i++) chk_dut(i);
    if (!rst) for (int i = 0; i < 3; i++) upd(i);
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0]  pat;
  logic [15:0] v16;
  logic [2:0]  p3, v3;

  initial begin
    rst = 1'b1; din8 = '0; lv8 = 1'b0; se8 = 1'b0; din1 = 1'b0; lv1 = 1'b0; se1 = 1'b0;
    mreset();
    @(negedge clk);
    cyc();
    rst = 1'b0;

    // 0x96 through both directions
    pat = 8'h96;
    din8 = pat; lv8 = 1'b1; se8 = 1'b1;
    cyc();
    lv8 = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk("t1_bit", so[0], pat[j]);
      chk("t2_bit", so[1], pat[7-j]);
      chk("t1_last", sl[0], j == 7);
      if (j == 1) begin
        chk("t1_shreg1", sh0, 8'h4B);
        chk("t2_shreg1", sh1, 8'h2C);
      end
      cyc();
    end
    chk("t1_idle", by[0], 1'b0);

    // back-to-back FF then 00
    din8 = 8'hFF; lv8 = 1'b1;
    cyc();
    din8 = 8'h00; v16 = '0;
    for (int j = 0; j < 16; j++) begin
      v16 = {v16[14:0], so[0]};
      chk("t3_valid", sv[0], 1'b1);
      chk("t3_ready", lr[0], (j == 7) || (j == 15));
      cyc();
    end
    chk("t3_stream", v16, 16'hFF00);
    lv8 = 1'b0;
    repeat (8) cyc();

    // stall after three bits of 0x96
    din8 = pat; lv8 = 1'b1;
    cyc();
    lv8 = 1'b0;
    repeat (3) cyc();
    se8 = 1'b0;
    for (int s = 0; s < 3; s++) begin
      lv8 = (s == 1); din8 = 8'hAA;
      chk("t4_cnt", bc0, 4'd5);
      chk("t4_bit", so[0], pat[3]);
      chk("t4_last", sl[0], 1'b0);
      chk("t4_ready", lr[0], 1'b0);
      cyc();
    end
    lv8 = 1'b0; se8 = 1'b1;
    for (int j = 3; j < 8; j++) begin
      chk("t4_resume", so[0], pat[j]);
      cyc();
    end

    // asynchronous reset in the middle of a word
    din8 = pat; lv8 = 1'b1;
    cyc();
    lv8 = 1'b0;
    repeat (3) cyc();
    #2 rst = 1'b1;
    #1;
    chk("t5_valid", sv[0], 1'b0);
    chk("t5_out", so[0], 1'b0);
    chk("t5_last", sl[0], 1'b0);
    chk("t5_busy", by[0], 1'b0);
    chk("t5_ready", lr[0], 1'b1);
    chk("t5_shreg", sh0, 8'h00);
    chk("t5_cnt", bc0, 4'd0);
    mreset();
    cyc();
    rst = 1'b0;
    din8 = 8'h01; lv8 = 1'b1;
    cyc();
    lv8 = 1'b0;
    chk("t5_bit0", so[0], 1'b1);
    repeat (8) cyc();

    // single-bit words, one per cycle
    p3 = 3'b101; v3 = '0;
    din1 = p3[2]; lv1 = 1'b1; se1 = 1'b1;
    cyc();
    for (int j = 0; j < 3; j++) begin
      chk("t6_last", sl[2], 1'b1);
      v3 = {v3[1:0], so[2]};
      if (j < 2) din1 = p3[1-j];
      else       lv1 = 1'b0;
      cyc();
    end
    chk("t6_stream", v3, 3'b101);

    // random traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      lv8 = ($urandom_range(9) < 6); se8 = ($urandom_range(3) != 0); din8 = 8'($urandom);
      lv1 = ($urandom_range(9) < 6); se1 = ($urandom_range(3) != 0); din1 = 1'($urandom);
      if ($urandom_range(63) == 0) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
      end else begin
        cyc();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/par2ser_stream.md
Name: par2ser_stream

Overview:
Parametrised parallel-to-serial converter. Accepts a WIDTH-bit word through a valid/ready load handshake and emits it one bit per enabled clock. Shift direction is selectable and a stall input is provided. The load handshake is Mealy: a new word is accepted on the last bit, so words stream back-to-back with no idle bubble. It sits between a parallel data source and a serial line driver, and replaces the fixed 8-bit shift-right converter.

Parameters:
WIDTH, 8, word width in bits (>=1)
LSB_FIRST, 1, 1 = shift right and emit bit 0 first; 0 = shift left and emit bit WIDTH-1 first
FILL, 1'b0, bit value shifted into the vacated end of the register
CW (localparam), $clog2(WIDTH+1), width of the remaining-bit counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
din  in  WIDTH  parallel word to load
load_valid  in  1  din is valid
load_ready  out  1  converter can accept din this cycle (combinational)
shift_en  in  1  consume the current serial bit at this edge; 0 = stall
ser_out  out  1  current serial bit
ser_valid  out  1  ser_out is meaningful
ser_last  out  1  ser_out is the final bit of the word
shreg  out  WIDTH  shift register contents (debug/parallel view)
bit_cnt  out  CW  bits remaining in the current word
busy  out  1  state == SHIFT

Behaviour:
- Reset (asynchronous, any time, including mid-word):
  - state=IDLE, shreg=0, bit_cnt=0.
  - Derived outputs: ser_valid=0, ser_out=0, ser_last=0, busy=0, load_ready=1.
  - Any word in progress is discarded.
- States: IDLE, SHIFT.
- load_ready = (state==IDLE) | (state==SHIFT & shift_en & bit_cnt==1). Mealy: depends on shift_en in the same cycle.
- Accept = load_valid & load_ready, taken at a rising edge. On accept:
  - shreg<=din, bit_cnt<=WIDTH, state<=SHIFT.
  - Latency: first bit appears on ser_out in the cycle after the accept edge.
- In SHIFT:
  - ser_valid=1.
  - ser_out = LSB_FIRST ? shreg[0] : shreg[WIDTH-1]. Combinational from the register, no extra flop.
  - ser_last = (bit_cnt==1).
- Edge with shift_en=1 and bit_cnt>1:
  - shreg shifts one place toward the output end; FILL enters the vacated end.
  - bit_cnt decrements.
  - The LSB-first case reproduces the legacy out>>1 behaviour with a zero fill.
- Edge with shift_en=1 and bit_cnt==1:
  - If load_valid=1, reload per the accept rule (back-to-back).
  - Otherwise state<=IDLE, bit_cnt<=0, and shreg takes the shifted value.
- shift_en=0 in SHIFT: all state holds; ser_out, ser_last and bit_cnt stay stable.
- load_valid in SHIFT while not on the last consumed bit: ignored (load_ready=0); din is not sampled.
- shift_en in IDLE: ignored.
- Throughput: with shift_en tied high and load_valid held high, exactly WIDTH cycles per word and a continuous ser_valid=1 stream.
- WIDTH=1: every word is ser_last from its first cycle; back-to-back delivers 1 word per cycle.
- Invalid parameters: WIDTH<1 is rejected by elaboration-time check.

Decomposition:
- Shared package/include par2ser_pkg holds:
  - state encoding constants: ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - a clog2 constant function for CW;
  - direction constants DIR_LSB=1, DIR_MSB=0.
- One natural sub-module: par2ser_bitcnt.
  - Interface: load with WIDTH, decrement on enable, flag is_last.
  - Parametrised on WIDTH; reusable by the matching ser2par block.
- Shift register and FSM stay in the top module.

Test Plan:
1. WIDTH=8, LSB_FIRST=1, FILL=0, din=8'h96, shift_en=1 -> ser_out 0,1,1,0,1,0,0,1 on cycles 1..8 after accept; ser_last only on cycle 8; shreg=8'h4B after first shift; IDLE after cycle 8.
2. Same din with LSB_FIRST=0 -> ser_out 1,0,0,1,0,1,1,0; shreg=8'h2C after first shift.
3. Back-to-back: load_valid held, din=8'hFF then 8'h00 -> load_ready high only in the ser_last cycle; 16 consecutive ser_valid cycles, 8 ones then 8 zeros, no gap.
4. Stall: shift_en=0 for 3 cycles after bit 3 of 8'h96 -> ser_out, bit_cnt=5 and ser_last held; sequence resumes unchanged; load_valid pulsed during the stall is not accepted.
5. Reset mid-word: assert rst asynchronously (between edges) during bit 4 -> all outputs immediately at reset values; after release, new din=8'h01 is accepted normally.
6. WIDTH=1, FILL=1: din alternating 1,0,1 with load_valid held -> ser_out 1,0,1 on consecutive cycles, ser_last=1 each cycle.
